// File: rtl/sdram_bus_pkg.sv
// Shared types and constants for the SDRAM DQ-bus engine: bus-ownership states,
// parameter legality limits and the read-hold counter sizing helper.
package sdram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } busState_e;

  localparam int CAS_LAT_MIN  = 1;
  localparam int CAS_LAT_MAX  = 3;
  localparam int TURN_CYC_MIN = 0;
  localparam int TURN_CYC_MAX = 3;

  // Width needed to hold the largest value the read-hold counter is loaded with.
  function automatic int rdHoldWidth(input int casLat, input int turnCyc);
    int maxLoad;
    maxLoad = casLat + turnCyc - 1;
    return (maxLoad < 2) ? 1 : $clog2(maxLoad + 1);
  endfunction

endpackage

// File: rtl/dq_pad_buf.sv
// One DQ pad bit: tristate output driver plus input path back into the core.
module dq_pad_buf (
  input  logic dOut,
  input  logic en,
  inout  wire  pad,
  output logic dIn
);

  assign pad = en ? dOut : 1'bz;
  assign dIn = pad;

endmodule

// File: rtl/sdram_dq_bus.sv
// SDRAM DQ-bus engine: registered write drive, CAS-aligned read capture and
// turnaround enforcement. Define SDRAM_DQ_INREG_EN to add a pad-side input register.
//
// state | meaning
// IDLE  | bus released, nothing in flight
// WRITE | driving write beats onto DQ
// READ  | read data outstanding on the pads
// TURN  | idle cycles before DQ may change direction
module sdram_dq_bus
  import sdram_bus_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CAS_LAT  = 2,
  parameter int TURN_CYC = 1
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  WrReq,
  input  logic [DATA_W-1:0]     WrData,
  input  logic [DATA_W/8-1:0]   WrMask,
  output logic                  WrAck,
  input  logic                  RdCmd,
  output logic [DATA_W-1:0]     RdData,
  output logic                  RdValid,
  output logic                  BusIdle,
  output logic                  ProtoErr,
  inout  wire  [DATA_W-1:0]     SDRAM_D,
  output logic [DATA_W/8-1:0]   SDRAM_DQM
);

  localparam int MASK_W = DATA_W / 8;
  localparam int HOLD_W = rdHoldWidth(CAS_LAT, TURN_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CAS_LAT + TURN_CYC - 1);
  localparam logic [1:0] TURN_LOAD = (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;

  if (CAS_LAT < CAS_LAT_MIN || CAS_LAT > CAS_LAT_MAX ||
      TURN_CYC < TURN_CYC_MIN || TURN_CYC > TURN_CYC_MAX ||
      (DATA_W % 8) != 0) begin : gBadParams
    $error("sdram_dq_bus: illegal DATA_W/CAS_LAT/TURN_CYC");
  end

  busState_e state, stateNext;
  logic [HOLD_W-1:0]  rdHold;
  logic [CAS_LAT-1:0] casPipe, casPipeNext;
  logic [CAS_LAT:0]   casPipeExt;
  logic [DATA_W-1:0]  outReg, outEn, padIn, capSrc, rdDataReg;
  logic [MASK_W-1:0]  dqmReg;
  logic [1:0]         turnCnt, driveGap, driveGapNow;
  logic               capStrobe, extraInFlight, rdValidReg, protoErrReg, protoViolation;

  assign WrAck = nReset & WrReq & ~RdCmd & (rdHold == '0);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      outEn  <= '0;
      outReg <= '0;
      dqmReg <= '0;
    end else begin
      outEn  <= {DATA_W{WrAck}};
      dqmReg <= WrAck ? WrMask : '0;
      if (WrAck) outReg <= WrData;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : gPad
    dq_pad_buf uPad (
      .dOut (outReg[i]),
      .en   (outEn[i]),
      .pad  (SDRAM_D[i]),
      .dIn  (padIn[i])
    );
  end

  // Pipe bit CAS_LAT-1 marks the cycle the SDRAM puts read data on the pads.
  assign casPipeExt  = {casPipe, RdCmd};
  assign casPipeNext = casPipeExt[CAS_LAT-1:0];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rdHold  <= '0;
      casPipe <= '0;
    end else begin
      casPipe <= casPipeNext;
      if (RdCmd)              rdHold <= HOLD_LOAD;
      else if (rdHold != '0)  rdHold <= rdHold - 1'b1;
    end
  end

`ifdef SDRAM_DQ_INREG_EN
  logic [DATA_W-1:0] padInReg;
  logic              inRegValid;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      padInReg   <= '0;
      inRegValid <= 1'b0;
    end else begin
      padInReg   <= padIn;
      inRegValid <= casPipe[CAS_LAT-1];
    end
  end

  assign capSrc        = padInReg;
  assign capStrobe     = inRegValid;
  assign extraInFlight = inRegValid;
`else
  assign capSrc        = padIn;
  assign capStrobe     = casPipe[CAS_LAT-1];
  assign extraInFlight = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rdDataReg  <= '0;
      rdValidReg <= 1'b0;
    end else begin
      rdValidReg <= capStrobe;
      if (capStrobe) rdDataReg <= capSrc;
    end
  end

  // Cycles since the last drive cycle, saturating; 0 while driving.
  assign driveGapNow    = outEn[0] ? 2'd0 : driveGap;
  assign protoViolation = RdCmd & ((int'(driveGapNow) + CAS_LAT) <= TURN_CYC);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      driveGap    <= 2'd3;
      protoErrReg <= 1'b0;
    end else begin
      driveGap    <= (driveGapNow == 2'd3) ? 2'd3 : driveGapNow + 2'd1;
      protoErrReg <= protoErrReg | protoViolation;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      turnCnt <= 2'd0;
    end else begin
      state <= stateNext;
      if (state != TURN && stateNext == TURN) turnCnt <= TURN_LOAD;
      else if (state == TURN && turnCnt != 2'd0) turnCnt <= turnCnt - 2'd1;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (RdCmd)      stateNext = READ;
        else if (WrAck) stateNext = WRITE;
      end
      WRITE: begin
        if (RdCmd)       stateNext = READ;
        else if (!WrAck) stateNext = (TURN_CYC > 0) ? TURN : IDLE;
      end
      READ: begin
        if (|casPipeNext) stateNext = READ;
        else if (WrAck)   stateNext = WRITE;
        else              stateNext = (TURN_CYC > 0) ? TURN : IDLE;
      end
      TURN: begin
        if (RdCmd)                  stateNext = READ;
        else if (WrAck)             stateNext = WRITE;
        else if (turnCnt == 2'd0)   stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign BusIdle   = (state == IDLE) & ~outEn[0] & ~|casPipe & (rdHold == '0) & ~extraInFlight;
  assign RdData    = rdDataReg;
  assign RdValid   = rdValidReg;
  assign ProtoErr  = protoErrReg;
  assign SDRAM_DQM = dqmReg;

endmodule

// File: tb/tb_sdram_dq_bus.sv
// Directed bench for sdram_dq_bus: default instance (CAS 2, turn 1) plus a
// CAS 1 / turn 2 instance for the write-to-read turnaround error.
module tb_sdram_dq_bus;

  localparam int TB_CAS = 2;
`ifdef SDRAM_DQ_INREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int RLAT  = TB_CAS + 1 + EXTRA;
  localparam int E_CAS = 1;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        wrReq = 1'b0, rdCmd = 1'b0;
  logic [15:0] wrData = '0, rdPat = '0;
  logic [1:0]  wrMask = '0;
  logic        wrAck, rdValid, busIdle, protoErr;
  logic [15:0] rdData;
  logic [1:0]  sdramDqm;
  wire  [15:0] sdramD;

  logic        eWrReq = 1'b0, eRdCmd = 1'b0;
  logic [15:0] eWrData = '0;
  logic [1:0]  eWrMask = '0;
  logic        eWrAck, eRdValid, eBusIdle, eProtoErr;
  logic [15:0] eRdData;
  logic [1:0]  eDqm;
  wire  [15:0] eD;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vCyc[$];
  logic [15:0] vDat[$];
  int eVCyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_dq_bus #(.DATA_W(16), .CAS_LAT(TB_CAS), .TURN_CYC(1)) dut (
    .Clock(clk), .nReset(nRst), .WrReq(wrReq), .WrData(wrData), .WrMask(wrMask),
    .WrAck(wrAck), .RdCmd(rdCmd), .RdData(rdData), .RdValid(rdValid),
    .BusIdle(busIdle), .ProtoErr(protoErr), .SDRAM_D(sdramD), .SDRAM_DQM(sdramDqm)
  );

  sdram_dq_bus #(.DATA_W(16), .CAS_LAT(E_CAS), .TURN_CYC(2)) dutErr (
    .Clock(clk), .nReset(nRst), .WrReq(eWrReq), .WrData(eWrData), .WrMask(eWrMask),
    .WrAck(eWrAck), .RdCmd(eRdCmd), .RdData(eRdData), .RdValid(eRdValid),
    .BusIdle(eBusIdle), .ProtoErr(eProtoErr), .SDRAM_D(eD), .SDRAM_DQM(eDqm)
  );

  // SDRAM model: answers each READ with its pattern CAS cycles later.
  logic [TB_CAS-1:0] cmdHist;
  logic [15:0]       valHist [TB_CAS];
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cmdHist <= '0;
      for (int i = 0; i < TB_CAS; i++) valHist[i] <= '0;
    end else begin
      cmdHist <= {cmdHist[TB_CAS-2:0], rdCmd};
      valHist[0] <= rdPat;
      for (int i = 1; i < TB_CAS; i++) valHist[i] <= valHist[i-1];
    end
  end
  assign sdramD = cmdHist[TB_CAS-1] ? valHist[TB_CAS-1] : 16'bz;

  always @(negedge clk) begin
    if (nRst && rdValid) begin
      vCyc.push_back(cyc);
      vDat.push_back(rdData);
    end
    if (nRst && eRdValid) eVCyc.push_back(cyc);
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 30; k++) begin
      if (busIdle && eBusIdle) break;
      tick();
    end
    checkEq("wait_idle", {31'd0, busIdle & eBusIdle}, 32'd1);
  endtask

  // Holds wrReq until acknowledged; returns the ack cycle or -1 on timeout.
  task automatic waitAck(output int ackCyc);
    ackCyc = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (wrAck) begin
        ackCyc = cyc;
        break;
      end
      tick();
    end
  endtask

  int m, n, ackCyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(); tick(); tick();
    wrReq = 1'b1;
    #1;
    checkEq("wrack_in_reset", {31'd0, wrAck}, 32'd0);
    wrReq = 1'b0;
    checkEq("rst_rdvalid", {31'd0, rdValid}, 32'd0);
    checkEq("rst_rddata", {16'd0, rdData}, 32'd0);
    checkEq("rst_protoerr", {31'd0, protoErr}, 32'd0);
    checkEq("rst_busidle", {31'd0, busIdle}, 32'd1);
    checkEq("rst_dqm", {30'd0, sdramDqm}, 32'd0);
    @(negedge clk) nRst = 1'b1;

    // Single write
    tick(); tick();
    n = cyc;
    wrReq = 1'b1; wrData = 16'hA55A; wrMask = 2'b01;
    #1;
    checkEq("wr_ack", {31'd0, wrAck}, 32'd1);
    tick();
    wrReq = 1'b0;
    checkEq("wr_drive_data", {16'd0, sdramD}, 32'h0000A55A);
    checkEq("wr_drive_dqm", {30'd0, sdramDqm}, 32'd1);
    checkEq("wr_busy", {31'd0, busIdle}, 32'd0);
    tick();
    checkEq("wr_dqm_release", {30'd0, sdramDqm}, 32'd0);
    checkEq("wr_turn_busy", {31'd0, busIdle}, 32'd0);
    tick();
    checkEq("wr_idle_after_turn", {31'd0, busIdle}, 32'd1);

    // Back-to-back read burst
    waitIdle();
    vCyc.delete(); vDat.delete();
    tick();
    m = cyc;
    rdCmd = 1'b1; rdPat = 16'h1111;
    tick(); rdPat = 16'h2222;
    tick(); rdPat = 16'h3333;
    tick(); rdCmd = 1'b0; rdPat = 16'h0000;
    for (int k = 0; k < 8; k++) tick();
    checkEq("burst_count", vCyc.size(), 32'd3);
    for (int i = 0; i < vCyc.size(); i++) begin
      checkEq("burst_cycle", vCyc[i], m + RLAT + i);
      checkEq("burst_data", {16'd0, vDat[i]}, 32'h1111 * (i + 1));
    end

    // Read followed by a held write request
    waitIdle();
    vCyc.delete(); vDat.delete();
    tick();
    m = cyc;
    rdCmd = 1'b1; rdPat = 16'h4444;
    tick();
    rdCmd = 1'b0; wrReq = 1'b1; wrData = 16'hBEEF; wrMask = 2'b00;
    waitAck(ackCyc);
    checkEq("turn_ack_cycle", ackCyc, m + 3);
    checkEq("turn_no_overlap", {31'd0, (ackCyc + 1) > (m + TB_CAS)}, 32'd1);
    tick();
    wrReq = 1'b0;
    checkEq("turn_drive_data", {16'd0, sdramD}, 32'h0000BEEF);
    for (int k = 0; k < 6; k++) tick();
    checkEq("turn_read_count", vCyc.size(), 32'd1);
    checkEq("turn_read_data", {16'd0, vDat[0]}, 32'h00004444);
    checkEq("turn_read_cycle", vCyc[0], m + RLAT);

    // Simultaneous RdCmd and WrReq from IDLE
    waitIdle();
    vCyc.delete(); vDat.delete();
    tick();
    m = cyc;
    rdCmd = 1'b1; rdPat = 16'h5555;
    wrReq = 1'b1; wrData = 16'h1357; wrMask = 2'b10;
    #1;
    checkEq("simul_wrack_low", {31'd0, wrAck}, 32'd0);
    tick();
    rdCmd = 1'b0;
    waitAck(ackCyc);
    checkEq("simul_ack_cycle", ackCyc, m + 3);
    tick();
    wrReq = 1'b0;
    checkEq("simul_drive_data", {16'd0, sdramD}, 32'h00001357);
    checkEq("simul_drive_dqm", {30'd0, sdramDqm}, 32'd2);
    for (int k = 0; k < 6; k++) tick();
    checkEq("simul_read_data", {16'd0, vDat[0]}, 32'h00005555);
    checkEq("simul_read_cycle", vCyc[0], m + RLAT);

    // Turnaround boundary on the CAS 1 / turn 2 instance: legal read
    waitIdle();
    tick();
    n = cyc;
    eWrReq = 1'b1; eWrData = 16'h00FF;
    #1;
    checkEq("err_wr_ack", {31'd0, eWrAck}, 32'd1);
    tick(); eWrReq = 1'b0;
    tick();
    tick(); eRdCmd = 1'b1;
    tick(); eRdCmd = 1'b0;
    checkEq("err_legal_read", {31'd0, eProtoErr}, 32'd0);

    // Violation: read issued during the drive cycle
    waitIdle();
    eVCyc.delete();
    tick();
    n = cyc;
    eWrReq = 1'b1;
    tick();
    eWrReq = 1'b0; eRdCmd = 1'b1;
    #1;
    checkEq("err_not_yet", {31'd0, eProtoErr}, 32'd0);
    tick();
    eRdCmd = 1'b0;
    checkEq("err_set", {31'd0, eProtoErr}, 32'd1);
    for (int k = 0; k < 6; k++) tick();
    checkEq("err_sticky", {31'd0, eProtoErr}, 32'd1);
    checkEq("err_read_count", eVCyc.size(), 32'd1);
    checkEq("err_read_cycle", eVCyc[0], n + 1 + E_CAS + 1 + EXTRA);

    // Reset in the middle of a read
    waitIdle();
    vCyc.delete(); vDat.delete();
    tick();
    m = cyc;
    rdCmd = 1'b1; rdPat = 16'h6666;
    tick();
    rdCmd = 1'b0;
    #1 nRst = 1'b0;
    wrReq = 1'b1;
    #1;
    checkEq("rst2_wrack", {31'd0, wrAck}, 32'd0);
    wrReq = 1'b0;
    checkEq("rst2_rdvalid", {31'd0, rdValid}, 32'd0);
    checkEq("rst2_rddata", {16'd0, rdData}, 32'd0);
    checkEq("rst2_busidle", {31'd0, busIdle}, 32'd1);
    checkEq("rst2_protoerr_cleared", {31'd0, eProtoErr}, 32'd0);
    tick(); tick();
    @(negedge clk) nRst = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checkEq("rst2_no_valid", vCyc.size(), 32'd0);
    checkEq("rst2_dqm", {30'd0, sdramDqm}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
